// File: rtl/sata_primitives.sv
// ---------------------------------------------------------------------------
// sata_primitives
//   Shared SATA link-layer constants: primitive dwords (first byte K28.x on
//   the wire, shown here in the usual big-endian dword notation), the link
//   scrambler seed/polynomial, and a byte-swap helper for PHYs that want
//   little-endian byte order.
// ---------------------------------------------------------------------------
package sata_primitives;

    localparam logic [31:0] P_ALIGN = 32'h7B4A_4ABC;
    localparam logic [31:0] P_CONT  = 32'h9999_AA7C;
    localparam logic [31:0] P_SYNC  = 32'hB5B5_957C;
    localparam logic [31:0] P_SOF   = 32'h3737_B57C;
    localparam logic [31:0] P_EOF   = 32'hD5D5_B57C;
    localparam logic [31:0] P_HOLD  = 32'hD5D5_AA7C;
    localparam logic [31:0] P_HOLDA = 32'h9595_AA7C;

    // Scrambler taps x^16+x^15+x^13+x^4+1 (x^16 term implied) and the seed
    // the junk generator starts from.
    localparam logic [31:0] SCRAMBLER_POLY = 32'h0000_A011;
    localparam logic [31:0] SCRAMBLER_SEED = 32'hC2D2_768D;

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/satalnk_contgen_junkgen.sv
// ---------------------------------------------------------------------------
// satalnk_junkgen
//   32-bit Galois LFSR producing the junk payload sent after a CONT.
//   o_junk is the current register value; it advances one step per cycle
//   with i_en high and returns to the scrambler seed on reset.
//   Ports:
//     i_clk    clock
//     i_reset  synchronous active-high reset (loads the seed)
//     i_en     advance to the next junk word
//     o_junk   current junk word
// ---------------------------------------------------------------------------
module satalnk_junkgen (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_en,
    output logic [31:0] o_junk
);
    import sata_primitives::*;

    logic [31:0] lfsr_q;
    logic [31:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (i_en) begin
            lfsr_d = {lfsr_q[30:0], 1'b0} ^ (lfsr_q[31] ? SCRAMBLER_POLY : 32'h0000_0000);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            lfsr_q <= SCRAMBLER_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign o_junk = lfsr_q;

endmodule

// File: rtl/satalnk_contgen.sv
// ---------------------------------------------------------------------------
// satalnk_contgen
//   SATA link transmit-side primitive shaper. Passes upstream words to the
//   PHY one register stage later, inserts ALIGN bursts every ALIGN_INTERVAL
//   PHY-accepted words, and replaces long runs of an identical repeatable
//   primitive with CONT followed by junk data words.
//
//   Handshake: an upstream word moves when s_valid && s_ready. s_ready is
//   high only when the PHY takes a word this cycle and no ALIGN slot is due,
//   so one accepted word always produces exactly one output word. A slot
//   where the PHY takes a word but s_valid is low is filled with SYNC.
//
//   Ports:
//     i_clk, i_reset      clock, synchronous active-high reset
//     i_cfg_continue_en   allow CONT substitution
//     s_valid/s_ready     upstream handshake
//     s_data[32:0]        bit 32 = primitive flag, [31:0] word
//     i_phy_ready         PHY consumes o_data this cycle
//     o_primitive/o_data  registered output word
//
//   Build option: define SATALNK_CONTGEN_JUNK_EN to draw junk words from
//   satalnk_junkgen; otherwise junk words are all-zero.
// ---------------------------------------------------------------------------
module satalnk_contgen #(
    parameter int OPT_LITTLE_ENDIAN = 0,
    parameter int ALIGN_INTERVAL    = 256,
    parameter int ALIGN_BURST       = 2,
    parameter int CONT_THRESHOLD    = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_cfg_continue_en,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [32:0] s_data,
    input  logic        i_phy_ready,
    output logic        o_primitive,
    output logic [31:0] o_data
);
    import sata_primitives::*;

    typedef enum logic [1:0] {
        ST_NORMAL      = 2'd0,
        ST_ALIGN_BURST = 2'd1,
        ST_CONT_SENT   = 2'd2
    } state_t;

    localparam int CNT_W   = $clog2(ALIGN_INTERVAL);
    localparam int BURST_W = $clog2(ALIGN_BURST + 1);
    localparam int RPT_W   = 3;

    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(ALIGN_INTERVAL - 1);
    localparam logic [BURST_W-1:0] BURST_END = BURST_W'(ALIGN_BURST);
    localparam logic [RPT_W-1:0]   RPT_CONT  = RPT_W'(CONT_THRESHOLD + 1);

    // Primitives in the byte order the PHY expects.
    localparam logic [31:0] W_ALIGN = (OPT_LITTLE_ENDIAN != 0) ? bswap32(P_ALIGN) : P_ALIGN;
    localparam logic [31:0] W_CONT  = (OPT_LITTLE_ENDIAN != 0) ? bswap32(P_CONT)  : P_CONT;
    localparam logic [31:0] W_SYNC  = (OPT_LITTLE_ENDIAN != 0) ? bswap32(P_SYNC)  : P_SYNC;
    localparam logic [31:0] W_SOF   = (OPT_LITTLE_ENDIAN != 0) ? bswap32(P_SOF)   : P_SOF;
    localparam logic [31:0] W_EOF   = (OPT_LITTLE_ENDIAN != 0) ? bswap32(P_EOF)   : P_EOF;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 align_due_q, align_due_d;
    logic [BURST_W-1:0]   burst_q, burst_d;
    logic [RPT_W-1:0]     rpt_q, rpt_d;
    logic [31:0]          last_q, last_d;
    logic                 prim_q, prim_d;
    logic [31:0]          data_q, data_d;

    logic [32:0]          in_word;
    logic                 elig;
    logic                 same;
    logic                 align_slot;
    logic [RPT_W-1:0]     rpt_inc;
    logic [BURST_W-1:0]   burst_n;
    logic [31:0]          junk_word;

    assign in_word    = s_valid ? s_data : {1'b1, W_SYNC};
    assign elig       = in_word[32] && (in_word[31:0] != W_ALIGN) && (in_word[31:0] != W_CONT)
                        && (in_word[31:0] != W_SOF) && (in_word[31:0] != W_EOF);
    // rpt_q == 0 means "no eligible primitive remembered" (reset, ALIGN, data).
    assign same       = elig && (rpt_q != '0) && (in_word[31:0] == last_q);
    assign align_slot = align_due_q || (state_q == ST_ALIGN_BURST);
    assign rpt_inc    = (rpt_q >= RPT_CONT) ? RPT_CONT : rpt_q + RPT_W'(1);

    assign s_ready = i_phy_ready && !i_reset && (state_q != ST_ALIGN_BURST) && !align_due_q;

`ifdef SATALNK_CONTGEN_JUNK_EN
    logic junk_adv;
    assign junk_adv = i_phy_ready && !align_slot && (state_q == ST_CONT_SENT)
                      && same && i_cfg_continue_en;

    satalnk_junkgen u_junkgen (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_en    (junk_adv),
        .o_junk  (junk_word)
    );
`else
    assign junk_word = 32'h0000_0000;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        align_due_d = align_due_q;
        burst_d     = burst_q;
        rpt_d       = rpt_q;
        last_d      = last_q;
        prim_d      = prim_q;
        data_d      = data_q;
        burst_n     = burst_q + BURST_W'(1);

        if (i_phy_ready) begin
            // Any slot holding align_due is an ALIGN slot and clears it, so
            // the flag simply follows the wrap of this slot.
            if (cnt_q == CNT_LAST) begin
                cnt_d       = '0;
                align_due_d = 1'b1;
            end else begin
                cnt_d       = cnt_q + CNT_W'(1);
                align_due_d = 1'b0;
            end

            if (align_slot) begin
                prim_d = 1'b1;
                data_d = W_ALIGN;
                rpt_d  = '0;
                if (burst_n == BURST_END) begin
                    state_d = ST_NORMAL;
                    burst_d = '0;
                end else begin
                    state_d = ST_ALIGN_BURST;
                    burst_d = burst_n;
                end
            end else begin
                case (state_q)
                    ST_CONT_SENT: begin
                        if (same && i_cfg_continue_en) begin
                            prim_d = 1'b0;
                            data_d = junk_word;
                        end else begin
                            // Run broken or CONT disabled: the word goes out
                            // verbatim (for a still-repeating primitive this
                            // is the held primitive) and counting restarts.
                            prim_d  = in_word[32];
                            data_d  = in_word[31:0];
                            rpt_d   = elig ? RPT_W'(1) : '0;
                            state_d = ST_NORMAL;
                            if (elig) begin
                                last_d = in_word[31:0];
                            end
                        end
                    end
                    default: begin
                        rpt_d = same ? rpt_inc : (elig ? RPT_W'(1) : '0);
                        if (elig) begin
                            last_d = in_word[31:0];
                        end
                        if (i_cfg_continue_en && (rpt_d == RPT_CONT)) begin
                            prim_d  = 1'b1;
                            data_d  = W_CONT;
                            state_d = ST_CONT_SENT;
                        end else begin
                            prim_d  = in_word[32];
                            data_d  = in_word[31:0];
                            state_d = ST_NORMAL;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ST_NORMAL;
            cnt_q       <= '0;
            align_due_q <= 1'b0;
            burst_q     <= '0;
            rpt_q       <= '0;
            last_q      <= '0;
            prim_q      <= 1'b1;
            data_q      <= W_SYNC;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            align_due_q <= align_due_d;
            burst_q     <= burst_d;
            rpt_q       <= rpt_d;
            last_q      <= last_d;
            prim_q      <= prim_d;
            data_q      <= data_d;
        end
    end

    assign o_primitive = prim_q;
    assign o_data      = data_q;

endmodule

// File: tb/tb_satalnk_contgen.sv
// ---------------------------------------------------------------------------
// tb_satalnk_contgen
//   Directed bench for satalnk_contgen with ALIGN_INTERVAL=16, ALIGN_BURST=2,
//   CONT_THRESHOLD=2. A run-length model predicts each output word; one
//   compare process checks o_primitive/o_data every cycle, the driver checks
//   s_ready every cycle, and literal tables pin key slots of each scenario.
//   Build with SATALNK_CONTGEN_JUNK_EN defined to expect LFSR junk words.
// ---------------------------------------------------------------------------
module tb_satalnk_contgen;
    import sata_primitives::*;

    localparam int AI = 16;
    localparam int AB = 2;
    localparam int TH = 2;

`ifdef SATALNK_CONTGEN_JUNK_EN
    localparam logic [31:0] J0 = 32'hC2D2_768D;
    localparam logic [31:0] J1 = 32'h85A4_4D0B;
    localparam logic [31:0] J2 = 32'h0B48_3A07;
`else
    localparam logic [31:0] J0 = 32'h0000_0000;
    localparam logic [31:0] J1 = 32'h0000_0000;
    localparam logic [31:0] J2 = 32'h0000_0000;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_cfg_continue_en = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [32:0] s_data = '0;
    logic        i_phy_ready = 1'b0;
    logic        o_primitive;
    logic [31:0] o_data;

    always #5 clk = ~clk;

    satalnk_contgen #(
        .OPT_LITTLE_ENDIAN (0),
        .ALIGN_INTERVAL    (AI),
        .ALIGN_BURST       (AB),
        .CONT_THRESHOLD    (TH)
    ) dut (
        .i_clk             (clk),
        .i_reset           (i_reset),
        .i_cfg_continue_en (i_cfg_continue_en),
        .s_valid           (s_valid),
        .s_ready           (s_ready),
        .s_data            (s_data),
        .i_phy_ready       (i_phy_ready),
        .o_primitive       (o_primitive),
        .o_data            (o_data)
    );

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [32:0] exp_q[$];
    logic [32:0] act_q[$];
    logic [32:0] cur_exp;
    bit          chk_en = 0;
    logic        last_acc;

    // ---------------- behavioural model ----------------
    int          slot_k;     // PHY-accepted slots since reset
    int          run;        // position in current run of identical eligible primitives
    logic [31:0] last_w;
    bit          cont_on;    // CONT already sent for the current run
    logic [31:0] mlfsr;

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit model_align();
        return (slot_k >= AI) && ((slot_k % AI) < AB);
    endfunction

    task automatic model_reset();
        slot_k  = 0;
        run     = 0;
        last_w  = '0;
        cont_on = 0;
        mlfsr   = SCRAMBLER_SEED;
    endtask

    task automatic model_slot(input logic [32:0] w, input logic en, output logic [32:0] o);
        bit elig;
        bit same;
        if (model_align()) begin
            o       = {1'b1, P_ALIGN};
            run     = 0;
            cont_on = 0;
        end else begin
            elig = w[32] && !(w[31:0] inside {P_ALIGN, P_CONT, P_SOF, P_EOF});
            same = elig && (run > 0) && (w[31:0] == last_w);
            run  = same ? run + 1 : (elig ? 1 : 0);
            if (elig) last_w = w[31:0];
            if (!same) cont_on = 0;
            if (en && run > TH) begin
                if (!cont_on) begin
                    o       = {1'b1, P_CONT};
                    cont_on = 1;
                end else begin
`ifdef SATALNK_CONTGEN_JUNK_EN
                    o     = {1'b0, mlfsr};
                    mlfsr = {mlfsr[30:0], 1'b0} ^ (mlfsr[31] ? SCRAMBLER_POLY : 32'h0);
`else
                    o = 33'h0_0000_0000;
`endif
                end
            end else begin
                o = w;
                if (cont_on) begin
                    cont_on = 0;
                    run     = 1;
                end
            end
        end
        slot_k++;
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            if (exp_q.size() > 0) begin
                cur_exp = exp_q.pop_front();
                act_q.push_back({o_primitive, o_data});
            end
            check("out_word", {o_primitive, o_data}, cur_exp);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input logic rst, input logic phy, input logic en,
                        input logic valid, input logic [32:0] data);
        logic        er;
        logic [32:0] o;
        @(negedge clk);
        #1;
        i_reset           = rst;
        i_phy_ready       = phy;
        i_cfg_continue_en = en;
        s_valid           = valid;
        s_data            = data;
        #1;
        er = phy && !rst && !model_align();
        check("s_ready", {32'h0, s_ready}, {32'h0, er});
        last_acc = er;
        if (rst) begin
            model_reset();
            exp_q.push_back({1'b1, P_SYNC});
        end else if (phy) begin
            model_slot(valid ? data : {1'b1, P_SYNC}, en, o);
            exp_q.push_back(o);
        end
    endtask

    task automatic do_reset(output int base);
        step(1'b1, 1'b1, 1'b0, 1'b0, '0);
        chk_en = 1;
        base   = act_q.size() + exp_q.size();
    endtask

    task automatic flush();
        step(1'b0, 1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic lit(input string name, input int idx, input logic [32:0] e);
        if (idx < act_q.size()) begin
            check(name, act_q[idx], e);
        end else begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: slot %0d never produced, expected %h", name, idx, e);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          base;
        int          rbase;
        int          widx;
        logic [32:0] w;

        repeat (2) @(posedge clk);

        // Reset state and 6x HOLD then HOLDA with CONT enabled.
        do_reset(base);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b1, 1'b1, {1'b1, P_HOLD});
        step(1'b0, 1'b1, 1'b1, 1'b1, {1'b1, P_HOLDA});
        step(1'b0, 1'b1, 1'b1, 1'b1, {1'b1, P_HOLD});
        flush();
        lit("reset_word", base - 1, {1'b1, P_SYNC});
        lit("hold_0",  base + 0, {1'b1, P_HOLD});
        lit("hold_1",  base + 1, {1'b1, P_HOLD});
        lit("cont",    base + 2, {1'b1, P_CONT});
        lit("junk_0",  base + 3, {1'b0, J0});
        lit("junk_1",  base + 4, {1'b0, J1});
        lit("junk_2",  base + 5, {1'b0, J2});
        lit("holda",   base + 6, {1'b1, P_HOLDA});
        lit("hold_nm", base + 7, {1'b1, P_HOLD});

        // HOLD repeating across an ALIGN burst.
        do_reset(base);
        for (int i = 0; i < 22; i++) step(1'b0, 1'b1, 1'b1, 1'b1, {1'b1, P_HOLD});
        flush();
        lit("xa_align0", base + 16, {1'b1, P_ALIGN});
        lit("xa_align1", base + 17, {1'b1, P_ALIGN});
        lit("xa_hold0",  base + 18, {1'b1, P_HOLD});
        lit("xa_hold1",  base + 19, {1'b1, P_HOLD});
        lit("xa_cont",   base + 20, {1'b1, P_CONT});
        if (base + 21 < act_q.size()) check("xa_junkflag", {32'h0, act_q[base + 21][32]}, 33'h0);

        // Idle SYNC with CONT disabled, then enabled, then dropped during junk.
        do_reset(base);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, 1'b0, '0);
        flush();
        for (int i = 0; i < 6; i++) lit("sync_pass", base + i, {1'b1, P_SYNC});
        lit("sync_cont",  base + 6, {1'b1, P_CONT});
        lit("sync_junk",  base + 7, {1'b0, J0});
        lit("sync_drop",  base + 8, {1'b1, P_SYNC});

        // PHY stall mid-CONT, then reset during an ALIGN burst.
        do_reset(base);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b1, {1'b1, P_HOLD});
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b1, {1'b1, P_HOLD});
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b1, 1'b1, {1'b1, P_HOLD});
        do_reset(rbase);
        step(1'b0, 1'b1, 1'b1, 1'b1, {1'b1, P_HOLD});
        for (int i = 0; i < 19; i++) step(1'b0, 1'b1, 1'b1, (i % 3) != 0, {1'b1, P_HOLD});
        flush();
        lit("stall_cont",  base + 2,  {1'b1, P_CONT});
        lit("stall_junk",  base + 4,  {1'b0, J1});
        lit("stall_align", base + 16, {1'b1, P_ALIGN});
        lit("rst_mid",     base + 17, {1'b1, P_SYNC});
        lit("post_rst",    rbase,     {1'b1, P_HOLD});
        lit("post_align",  rbase + 16, {1'b1, P_ALIGN});

        // Data stream with periodic PHY stalls: ALIGN cadence, no loss.
        do_reset(base);
        widx = 0;
        for (int i = 0; i < 48; i++) begin
            w = {1'b0, 32'h1000_0000 + 32'(widx)};
            step(1'b0, (i % 7) != 3, 1'b1, 1'b1, w);
            if (last_acc) widx++;
        end
        flush();
        lit("ds_word15", base + 15, {1'b0, 32'h1000_000F});
        lit("ds_align0", base + 16, {1'b1, P_ALIGN});
        lit("ds_align1", base + 17, {1'b1, P_ALIGN});
        lit("ds_word16", base + 18, {1'b0, 32'h1000_0010});
        lit("ds_align2", base + 32, {1'b1, P_ALIGN});
        lit("ds_word30", base + 34, {1'b0, 32'h1000_001E});

        // Ineligible words never collapse into CONT.
        do_reset(base);
        for (int i = 0; i < 16; i++) begin
            case (i / 4)
                0:       w = {1'b1, P_SOF};
                1:       w = {1'b1, P_EOF};
                2:       w = {1'b1, P_ALIGN};
                default: w = {1'b0, P_HOLD};
            endcase
            step(1'b0, 1'b1, 1'b1, 1'b1, w);
        end
        flush();
        lit("sof_rep",   base + 3,  {1'b1, P_SOF});
        lit("eof_rep",   base + 7,  {1'b1, P_EOF});
        lit("align_rep", base + 11, {1'b1, P_ALIGN});
        lit("data_rep",  base + 15, {1'b0, P_HOLD});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/satalnk_contgen.md
SATALNK_CONTGEN -- requirements
Module: satalnk_contgen

Interface
REQ-001 SHALL have parameter OPT_LITTLE_ENDIAN, default 0, meaning byte-swap all generated primitives for little-endian PHY order.
REQ-002 SHALL have parameter ALIGN_INTERVAL, default 256, meaning output words between ALIGN bursts (range 8..4096).
REQ-003 SHALL have parameter ALIGN_BURST, default 2, meaning consecutive ALIGNs per burst (range 1..8).
REQ-004 SHALL have parameter CONT_THRESHOLD, default 2, meaning identical primitives sent verbatim before CONT (range 2..4).
REQ-005 SHALL have ports, one clock, synchronous active-high reset:
 i_clk  in  1  sole clock
 i_reset  in  1  synchronous, active-high reset
 i_cfg_continue_en  in  1  enable CONT substitution
 s_valid  in  1  upstream word valid
 s_ready  out  1  upstream word accepted this cycle
 s_data  in  33  bit 32 = primitive flag, [31:0] word
 i_phy_ready  in  1  PHY consumes o_data this cycle
 o_primitive  out  1  output primitive flag
 o_data  out  32  output word

Function
REQ-006 SHALL register outputs; s_data accepted in cycle N appears on o_data in cycle N+1.
REQ-007 SHALL hold o_primitive/o_data stable while i_phy_ready is low; internal state advances only when i_phy_ready is high.
REQ-008 SHALL drive s_ready = i_phy_ready && state != ALIGN_BURST && !align_due.
REQ-009 SHALL treat an accept slot with s_valid low as input P_SYNC primitive.
REQ-010 SHALL count PHY-accepted words in a counter of clog2(ALIGN_INTERVAL) bits; at ALIGN_INTERVAL-1 it SHALL set align_due and wrap to 0.
REQ-011 SHALL use states NORMAL, ALIGN_BURST, CONT_SENT; with align_due, next PHY-accepted slot enters ALIGN_BURST from any state.
REQ-012 ALIGN_BURST SHALL emit exactly ALIGN_BURST P_ALIGN words, then return to NORMAL with repeat count cleared.
REQ-013 CONT-eligible words SHALL be primitives other than P_ALIGN, P_CONT, P_SOF, P_EOF; data words never eligible.
REQ-014 In NORMAL, an eligible primitive equal to the last eligible primitive SHALL increment a saturating repeat count; any other word SHALL reset it to 1 (0 for ineligible).
REQ-015 When i_cfg_continue_en and repeat count reaches CONT_THRESHOLD+1, SHALL emit P_CONT and enter CONT_SENT.
REQ-016 In CONT_SENT, further identical eligible primitives SHALL emit junk data words (o_primitive=0).
REQ-017 In CONT_SENT, a different word SHALL be emitted verbatim, transition to NORMAL, repeat count 1 (or 0).
REQ-018 After ALIGN_BURST, a still-repeating primitive SHALL be re-sent CONT_THRESHOLD times before a new P_CONT.
REQ-019 With i_cfg_continue_en low, all words SHALL pass verbatim; deassertion in CONT_SENT SHALL re-emit held primitive next slot and enter NORMAL.
REQ-020 ALIGN insertion SHALL take priority over CONT/junk on the same slot.

Reset
REQ-021 On i_reset: state NORMAL, counters 0, align_due 0, repeat count 0, o_primitive 1, o_data P_SYNC, s_ready 0 that cycle.
REQ-022 Reset mid-burst or mid-CONT SHALL abandon it; the first post-reset accepted word passes verbatim.

Configuration
REQ-023 Macro SATALNK_CONTGEN_JUNK_EN defined: junk words SHALL come from a 32-bit LFSR (polynomial as the link scrambler, seed 32'hC2D2768D), advancing per junk word, reset to seed.
REQ-024 Macro undefined: junk words SHALL be constant 32'h0000_0000; no LFSR logic.

Structure
REQ-025 P_ALIGN, P_CONT, P_SYNC, P_SOF, P_EOF, P_HOLD and scrambler seed/polynomial SHALL come from shared sata_primitives package; state encoding local.
REQ-026 Junk LFSR SHALL be sub-module satalnk_junkgen (enable, reset, 32-bit out).

Verification (ALIGN_INTERVAL=16, ALIGN_BURST=2, CONT_THRESHOLD=2)
REQ-027 i_phy_ready=1, stream data words -> every 16th accepted slot starts 2 P_ALIGN, s_ready low those 2 cycles, no data lost/reordered.
REQ-028 continue_en=1, 6x P_HOLD -> output HOLD, HOLD, CONT, junk, junk, junk; then P_HOLDA -> HOLDA verbatim, state NORMAL.
REQ-029 P_HOLD repeating across ALIGN burst -> ALIGN, ALIGN, HOLD, HOLD, CONT, junk.
REQ-030 continue_en=0, 6x P_SYNC -> six P_SYNC; continue_en dropped during junk -> next word P_SYNC.
REQ-031 i_phy_ready low 5 cycles mid-CONT -> o_data frozen, counters unchanged; i_reset mid-burst -> next cycle o_data P_SYNC, counters 0.
REQ-032 JUNK_EN defined -> first junk equals satalnk_junkgen first output from seed; undefined -> junk 32'h0.
